// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised pixel timing generator with scroll and CPU register window
//
// Purpose: generates hsync/vsync/de for a programmable raster, scrolled active pixel
// coordinates, a frame-start pulse and a frame interrupt. Scroll registers are shadowed
// and copied to the active set only on the last pixel of a frame.
//
// Ports:
//   clk_pixel    pixel clock, the only clock
//   reset        asynchronous active-high reset
//   sel          register access strobe
//   wren[3:0]    byte write strobes, all zero = read
//   address[1:0] word select: 0 SCROLL_X, 1 SCROLL_Y, 2 CTRL, 3 STATUS
//   data_in      write data
//   data_out     read data, updated one cycle after a read strobe
//   hsync/vsync  syncs, polarity set by HSYNC_POL/VSYNC_POL
//   de           data enable
//   pixel_x/y    scrolled active coordinates, held while de is low
//   frame_start  one-cycle pulse at pixel (0,0)
//   irq          level interrupt = frame_pending & irq_en
module video_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int CNT_W     = 12,
   parameter int START_X   = 0,
   parameter int START_Y   = 0
) (
   input  logic             clk_pixel,
   input  logic             reset,
   input  logic             sel,
   input  logic [3:0]       wren,
   input  logic [1:0]       address,
   input  logic [31:0]      data_in,
   output logic [31:0]      data_out,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             frame_start,
   output logic             irq
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] C_V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] C_H_SS     = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] C_H_SE     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] C_V_SS     = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] C_V_SE     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
   localparam logic             C_HS_ON    = (HSYNC_POL != 0);
   localparam logic             C_VS_ON    = (VSYNC_POL != 0);

   logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
   logic [CNT_W-1:0] r_scroll_x, r_scroll_y, r_scroll_x_act, r_scroll_y_act;
   logic             r_enable, r_irq_en, r_frame_pending;
   logic [15:0]      r_frame_count;
   logic             r_hsync, r_vsync, r_de, r_frame_start, r_irq;
   logic [CNT_W-1:0] r_pixel_x, r_pixel_y;
   logic [31:0]      r_data_out;

   logic             w_commit, w_de, w_hs_on, w_vs_on, w_vblank;
   logic             w_wr, w_rd, w_clr;
   logic             w_pending_nxt, w_irq_en_nxt;
   logic [1:0]       w_ctrl_wr;
   logic [31:0]      w_rd_data;

   // Byte-lane merge of a write into the current register contents.
   function automatic logic [31:0] f_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
      f_lanes = old_v;
      for (int i = 0; i < 4; i++)
         if (be[i]) f_lanes[8*i +: 8] = new_v[8*i +: 8];
   endfunction

   assign w_commit = (r_h_cnt == C_H_LAST) && (r_v_cnt == C_V_LAST);
   assign w_de     = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT) && r_enable;
   assign w_hs_on  = (r_h_cnt >= C_H_SS) && (r_h_cnt < C_H_SE);
   assign w_vs_on  = (r_v_cnt >= C_V_SS) && (r_v_cnt < C_V_SE);
   assign w_vblank = (r_v_cnt >= C_V_ACT);

   assign w_wr = sel && (wren != 4'd0);
   assign w_rd = sel && (wren == 4'd0);
   assign w_clr = w_wr && (address == 2'd3) && wren[0] && data_in[1];

   assign w_ctrl_wr     = 2'(f_lanes(32'({r_irq_en, r_enable}), data_in, wren));
   assign w_irq_en_nxt  = (w_wr && address == 2'd2) ? w_ctrl_wr[1] : r_irq_en;
   // A commit sets pending even if a W1C clear lands on the same cycle.
   assign w_pending_nxt = w_commit ? 1'b1 : (w_clr ? 1'b0 : r_frame_pending);

   always_comb begin
      w_rd_data = 32'd0;
      case (address)
         2'd0:    w_rd_data = 32'(r_scroll_x);
         2'd1:    w_rd_data = 32'(r_scroll_y);
         2'd2:    w_rd_data = {30'd0, r_irq_en, r_enable};
         default: w_rd_data = {r_frame_count, 14'd0, r_frame_pending, w_vblank};
      endcase
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         r_h_cnt <= CNT_W'(START_X);
         r_v_cnt <= CNT_W'(START_Y);
      end else if (r_h_cnt == C_H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + C_ONE;
      end else begin
         r_h_cnt <= r_h_cnt + C_ONE;
      end
   end

   // Register file; the active scroll copy samples the shadow before any same-cycle write.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         r_scroll_x      <= '0;
         r_scroll_y      <= '0;
         r_scroll_x_act  <= '0;
         r_scroll_y_act  <= '0;
         r_enable        <= 1'b1;
         r_irq_en        <= 1'b0;
         r_frame_pending <= 1'b0;
         r_frame_count   <= 16'd0;
      end else begin
         if (w_commit) begin
            r_scroll_x_act <= r_scroll_x;
            r_scroll_y_act <= r_scroll_y;
            r_frame_count  <= r_frame_count + 16'd1;
         end
         if (w_wr) begin
            case (address)
               2'd0:    r_scroll_x <= CNT_W'(f_lanes(32'(r_scroll_x), data_in, wren));
               2'd1:    r_scroll_y <= CNT_W'(f_lanes(32'(r_scroll_y), data_in, wren));
               2'd2:    {r_irq_en, r_enable} <= w_ctrl_wr;
               default: ;
            endcase
         end
         r_frame_pending <= w_pending_nxt;
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         r_hsync       <= !C_HS_ON;
         r_vsync       <= !C_VS_ON;
         r_de          <= 1'b0;
         r_frame_start <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_irq         <= 1'b0;
         r_data_out    <= 32'd0;
      end else begin
         r_hsync       <= w_hs_on ? C_HS_ON : !C_HS_ON;
         r_vsync       <= w_vs_on ? C_VS_ON : !C_VS_ON;
         r_de          <= w_de;
         r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
         if (w_de) begin
            r_pixel_x <= r_h_cnt + r_scroll_x_act;
            r_pixel_y <= r_v_cnt + r_scroll_y_act;
         end
         r_irq <= w_pending_nxt & w_irq_en_nxt;
         if (w_rd) r_data_out <= w_rd_data;
      end
   end

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign pixel_x     = r_pixel_x;
   assign pixel_y     = r_pixel_y;
   assign frame_start = r_frame_start;
   assign irq         = r_irq;
   assign data_out    = r_data_out;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a 16x8 raster
module tb_video_timing_gen;

   localparam int HT      = 16;
   localparam int VT      = 8;
   localparam int FRAME   = HT * VT;
   localparam int START_Y = 6;

   logic        clk_pixel = 1'b0;
   logic        reset     = 1'b0;
   logic        sel       = 1'b0;
   logic [3:0]  wren      = 4'd0;
   logic [1:0]  address   = 2'd0;
   logic [31:0] data_in   = 32'd0;
   logic [31:0] data_out;
   logic        hsync, vsync, de, frame_start, irq;
   logic [11:0] pixel_x, pixel_y;

   video_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
      .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(12), .START_X(0), .START_Y(START_Y)
   ) dut (
      .clk_pixel(clk_pixel), .reset(reset), .sel(sel), .wren(wren), .address(address),
      .data_in(data_in), .data_out(data_out), .hsync(hsync), .vsync(vsync), .de(de),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start), .irq(irq)
   );

   always #5 clk_pixel = ~clk_pixel;

   typedef struct {
      logic        hs, vs, de, fs, irq;
      logic [11:0] px, py;
      logic [31:0] dout;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   mon_cyc = 0;
   int   last_fs = -1;

   // Reference model: raster position as a single linear index into the frame.
   int          m_pos;
   logic [11:0] m_sx, m_sy, m_sx_act, m_sy_act, m_px, m_py;
   logic        m_en, m_irq_en, m_pend;
   logic [15:0] m_fcnt;
   logic [31:0] m_dout;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] d,
                                         input logic [3:0] be);
      lanes = old_v;
      for (int i = 0; i < 4; i++)
         if (be[i]) lanes[8*i +: 8] = d[8*i +: 8];
   endfunction

   task automatic model_reset();
      m_pos = START_Y * HT;
      m_sx = 0; m_sy = 0; m_sx_act = 0; m_sy_act = 0; m_px = 0; m_py = 0;
      m_en = 1'b1; m_irq_en = 1'b0; m_pend = 1'b0; m_fcnt = 16'd0; m_dout = 32'd0;
   endtask

   // Advance the model across one clock edge using the inputs the DUT just sampled.
   task automatic model_step();
      int          h, v;
      exp_t        e;
      logic [31:0] t;
      bit          commit;
      h = m_pos % HT;
      v = m_pos / HT;
      e.hs = (h >= 10 && h < 13);
      e.vs = (v == 5);
      e.de = (h < 8) && (v < 4) && m_en;
      if (e.de) begin
         m_px = 12'(h) + m_sx_act;
         m_py = 12'(v) + m_sy_act;
      end
      e.px = m_px;
      e.py = m_py;
      e.fs = (m_pos == 0);
      if (sel && wren == 4'd0) begin
         case (address)
            2'd0: m_dout = {20'd0, m_sx};
            2'd1: m_dout = {20'd0, m_sy};
            2'd2: m_dout = {30'd0, m_irq_en, m_en};
            default: m_dout = {m_fcnt, 14'd0, m_pend, logic'(v >= 4)};
         endcase
      end
      e.dout = m_dout;
      commit = (m_pos == FRAME - 1);
      if (commit) begin
         m_sx_act = m_sx;
         m_sy_act = m_sy;
         m_fcnt   = m_fcnt + 16'd1;
         m_pend   = 1'b1;
      end
      if (sel && wren != 4'd0) begin
         case (address)
            2'd0: begin t = lanes({20'd0, m_sx}, data_in, wren); m_sx = t[11:0]; end
            2'd1: begin t = lanes({20'd0, m_sy}, data_in, wren); m_sy = t[11:0]; end
            2'd2: begin t = lanes({30'd0, m_irq_en, m_en}, data_in, wren);
                        m_en = t[0]; m_irq_en = t[1]; end
            default: if (wren[0] && data_in[1] && !commit) m_pend = 1'b0;
         endcase
      end
      e.irq = m_pend & m_irq_en;
      m_pos = (m_pos + 1) % FRAME;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk_pixel);
      #1;
      model_step();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic access(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
      sel = 1'b1; address = a; wren = be; data_in = d;
      tick();
      sel = 1'b0; wren = 4'd0; data_in = 32'd0;
   endtask

   // Leave the inputs pointing at the commit edge.
   task automatic to_commit();
      int n = 0;
      while (m_pos != FRAME - 1 && n < 2 * FRAME) begin
         tick();
         n++;
      end
   endtask

   task automatic check_reset_vals();
      check("rst_hsync", 32'(hsync), 32'd0);
      check("rst_vsync", 32'(vsync), 32'd0);
      check("rst_de", 32'(de), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_pixel_x", 32'(pixel_x), 32'd0);
      check("rst_pixel_y", 32'(pixel_y), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_data_out", data_out, 32'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_pixel);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mon_cyc++;
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("de", 32'(de), 32'(e.de));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("pixel_x", 32'(pixel_x), 32'(e.px));
            check("pixel_y", 32'(pixel_y), 32'(e.py));
            check("irq", 32'(irq), 32'(e.irq));
            check("data_out", data_out, e.dout);
            if (frame_start) begin
               if (last_fs >= 0) check("frame_period", 32'(mon_cyc - last_fs), 32'(FRAME));
               last_fs = mon_cyc;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      model_reset();
      #2 reset = 1'b1;
      #1 check_reset_vals();
      repeat (3) @(posedge clk_pixel);
      #1 reset = 1'b0;
      model_reset();
      last_fs = -1;

      // Free run: three frames from START_Y.
      idle(3 * FRAME + 40);

      // Mid-frame scroll write, then readback.
      access(2'd0, 4'hF, 32'd5);
      access(2'd0, 4'h0, 32'd0);
      to_commit();
      idle(FRAME + 20);

      // Scroll near the top of the coordinate range.
      access(2'd0, 4'h3, 32'h0000_0FFE);
      to_commit();
      idle(FRAME + 8);
      access(2'd0, 4'hF, 32'd0);

      // SCROLL_Y written exactly on the commit edge.
      to_commit();
      access(2'd1, 4'hF, 32'd2);
      idle(2 * FRAME);
      access(2'd1, 4'h0, 32'd0);

      // Interrupt path with display disabled.
      access(2'd2, 4'h1, 32'h2);
      access(2'd3, 4'h0, 32'd0);
      to_commit();
      idle(4);
      access(2'd3, 4'h0, 32'd0);
      access(2'd3, 4'h1, 32'h2);
      idle(4);
      to_commit();
      access(2'd3, 4'h1, 32'h2);
      idle(4);
      access(2'd3, 4'h1, 32'h2);
      access(2'd2, 4'hF, 32'h1);

      // Random register traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0)
            access(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom());
         else
            tick();
      end
      access(2'd2, 4'hF, 32'h1);
      idle(FRAME);

      // Asynchronous reset while hsync is high mid-line.
      while ((m_pos % HT) != 12) tick();
      #6 reset = 1'b1;
      #1 check_reset_vals();
      repeat (2) @(posedge clk_pixel);
      #1 reset = 1'b0;
      sb_q.delete();
      model_reset();
      last_fs = -1;
      idle(2 * HT + 8);

      @(negedge clk_pixel);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised pixel-timing generator for the video subsystem. It produces hsync, vsync and data-enable for an arbitrary resolution and sync polarity. It also produces scrolled active-pixel coordinates and a frame-start pulse, and exposes a small CPU register window (sel / wren / address / data) on the pixel clock. Scroll registers are double-buffered and commit only at frame boundaries, so CPU writes never tear a frame. Its outputs feed the pixel fetch and the TMDS encoders; clock-domain crossing from the CPU happens upstream of this block.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line
- H_FRONT, 16: horizontal front porch
- H_SYNC, 96: hsync width
- H_BACK, 48: horizontal back porch
- V_ACTIVE, 480: active lines
- V_FRONT, 10: vertical front porch
- V_SYNC, 2: vsync width
- V_BACK, 33: vertical back porch
- HSYNC_POL, 0: 1 = hsync asserted high
- VSYNC_POL, 0: 1 = vsync asserted high
- CNT_W, 12: counter and coordinate width; must satisfy H_TOTAL, V_TOTAL ≤ 2^CNT_W
- START_X, 0: h counter value at reset (simulation shortcut)
- START_Y, 0: v counter value at reset (simulation shortcut)

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high reset
- sel  in  1  register access strobe
- wren  in  4  byte write strobes; 0 = read
- address  in  2  word select
- data_in  in  32  write data
- data_out  out  32  read data
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  data enable
- pixel_x  out  CNT_W  scrolled active x
- pixel_y  out  CNT_W  scrolled active y
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- irq  out  1  frame interrupt, level

## Operation
- H_TOTAL = sum of the four H params; V_TOTAL = sum of the four V params.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. On that wrap, v_cnt increments, and wraps 0 after V_TOTAL-1.
- Line layout: active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), then back porch. Vertical layout is identical.
- de = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE) & CTRL.enable. Syncs run regardless of enable.
- pixel_x = (h_cnt + scroll_x_act) mod 2^CNT_W; pixel_y = (v_cnt + scroll_y_act) mod 2^CNT_W. Both hold their last value when de=0.
- Registers (word address):
  - 0 SCROLL_X shadow: bits [CNT_W-1:0]; reset 0.
  - 1 SCROLL_Y shadow: bits [CNT_W-1:0]; reset 0.
  - 2 CTRL: bit0 enable (reset 1), bit1 irq_en (reset 0). Takes effect immediately.
  - 3 STATUS: bit0 in_vblank (v_cnt ≥ V_ACTIVE), bit1 frame_pending, bits [31:16] frame_count. Writing 1 to bit1 clears frame_pending; other bits are read-only.
- Writes apply per byte lane (wren[i] writes data_in[8i+7:8i]). Unimplemented bits read 0.
- Commit point: the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
  - Copy both shadows into scroll_x_act / scroll_y_act.
  - frame_count += 1 (wraps at 16 bits).
  - Set frame_pending.
- A write landing on the commit cycle updates the shadow; the active copy takes the pre-write shadow value.
- A frame_pending set and a W1C clear in the same cycle: set wins.
- irq = frame_pending & irq_en.

## Timing
- All outputs are registered. hsync, vsync, de, pixel_x/y and frame_start reflect the counter state of the previous cycle, so latency from counter to pins is 1 cycle.
- frame_start is high for exactly one cycle, aligned with the first de of a frame (provided enable=1).
- Reads return data_out one cycle after sel=1 with wren=0; data_out holds until the next read. Writes take effect on the next clock edge.
- Reset is asynchronous and releases on a clk_pixel edge. Values during reset:
  - h_cnt=START_X, v_cnt=START_Y
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL
  - de=0, frame_start=0, pixel_x/y=0, data_out=0, irq=0
  - shadow and active scroll = 0, CTRL = 0x1, frame_count = 0, frame_pending = 0
- Reset mid-line discards the frame with no partial commit. Counting restarts from START_X/START_Y on the first clock edge after release.

## Test plan
All scenarios use small parameters: H 8/2/3/3 (H_TOTAL 16), V 4/1/1/2 (V_TOTAL 8), both polarities 1.
- Free-run 3 frames after reset:
  - frame_start every 128 cycles
  - 32 de cycles per frame
  - hsync high 3 cycles per line, starting 10 cycles after the line's first de
  - vsync high 16 cycles per frame
- Write SCROLL_X=5 mid-frame: pixel_x sequence stays 0..7 until after the next commit, then runs 5..12. Read back SCROLL_X=5 one cycle after the read strobe.
- Write SCROLL_X=0xFFE: pixel_x runs 0xFFE, 0xFFF, 0x000, … (wrap at CNT_W).
- Write SCROLL_Y=2 exactly on the commit cycle: the next frame uses the old value, the frame after uses 2.
- CTRL=0x2 (irq_en=1, enable=0):
  - de stays 0 while syncs continue
  - irq rises after the commit and frame_count increments
  - writing STATUS bit1=1 drops irq the next cycle
  - a clear issued on a commit cycle leaves irq high
- Assert reset mid-line: outputs go to reset values asynchronously; after release with START_Y=6, the first frame_start occurs 2*16 = 32 cycles later.
